// File: rtl/mem_stage_if.sv
// Bundle of all signals between the memory stage and its neighbours:
// the execute stage, write-back, decode and the data SRAM.
interface mem_stage_if #(
  parameter int unsigned EXE_TO_MEM_WD = 176,
  parameter int unsigned MEM_TO_WB_WD  = 176,
  parameter int unsigned MEM_TO_ID_WD  = 41
) ();
  logic                     mem_allowin;
  logic                     exe_to_mem_valid;
  logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus;
  logic                     wb_allowin;
  logic                     mem_to_wb_valid;
  logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus;
  logic                     wb_to_mem_flush;
  logic                     mem_to_exe_flush_excp_ertn;
  logic                     data_sram_data_ok;
  logic [31:0]              data_sram_rdata;

  modport slave (
    input  exe_to_mem_valid, exe_to_mem_bus, wb_allowin, wb_to_mem_flush,
           data_sram_data_ok, data_sram_rdata,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus,
           mem_to_exe_flush_excp_ertn
  );

  modport master (
    output exe_to_mem_valid, exe_to_mem_bus, wb_allowin, wb_to_mem_flush,
           data_sram_data_ok, data_sram_rdata,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus,
           mem_to_exe_flush_excp_ertn
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, extracts load
// data, forwards to decode and drops responses orphaned by a flush.
module mem_stage #(
  parameter int unsigned EXE_TO_MEM_WD = 176,
  parameter int unsigned MEM_TO_WB_WD  = 176,
  parameter int unsigned MEM_TO_ID_WD  = 41
) (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave mem_if
);

  logic                     r_mem_valid;
  logic [EXE_TO_MEM_WD-1:0] r_bus;
  logic                     r_data_got;
  logic [31:0]              r_data_buf;
  logic                     r_cancel;

  logic        w_memW, w_regW, w_res_from_mem, w_load_sign, w_excp, w_ertn;
  logic [4:0]  w_regWAddr;
  logic [31:0] w_result;
  logic [1:0]  w_memINS_rec, w_csr_instRec, w_rdcnt_REC;
  logic        w_need_data, w_ready_go, w_allowin, w_to_wb_valid, w_flush;
  logic        w_data_ok, w_out_regW, w_load_pending, w_exist_csrR;
  logic [31:0] w_rdata_sel, w_load_value, w_final_result;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [MEM_TO_WB_WD-1:0] w_wb_bus;
  logic [MEM_TO_ID_WD-1:0] w_id_bus;

  assign w_memW         = r_bus[175];
  assign w_regW         = r_bus[174];
  assign w_regWAddr     = r_bus[173:169];
  assign w_res_from_mem = r_bus[168];
  assign w_result       = r_bus[167:136];
  assign w_memINS_rec   = r_bus[135:134];
  assign w_load_sign    = r_bus[133];
  assign w_csr_instRec  = r_bus[54:53];
  assign w_excp         = r_bus[52];
  assign w_ertn         = r_bus[51];
  assign w_rdcnt_REC    = r_bus[36:35];

  assign w_flush     = mem_if.wb_to_mem_flush;
  assign w_data_ok   = mem_if.data_sram_data_ok;
  assign w_need_data = r_mem_valid & (w_memW | w_res_from_mem) & ~w_excp;
  // While r_cancel is set the incoming data_ok belongs to a flushed instruction.
  assign w_ready_go    = ~w_need_data | r_data_got | (w_data_ok & ~r_cancel);
  assign w_allowin     = ~r_mem_valid | (w_ready_go & mem_if.wb_allowin);
  assign w_to_wb_valid = r_mem_valid & w_ready_go & ~w_flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem_valid <= 1'b0;
    end else if (w_flush) begin
      r_mem_valid <= 1'b0;
    end else if (w_allowin) begin
      r_mem_valid <= mem_if.exe_to_mem_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_allowin && mem_if.exe_to_mem_valid) begin
      r_bus <= mem_if.exe_to_mem_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || w_flush || (w_to_wb_valid && mem_if.wb_allowin)) begin
      r_data_got <= 1'b0;
      r_data_buf <= 32'd0;
    end else if (w_data_ok && !r_cancel && w_need_data && !r_data_got) begin
      r_data_got <= 1'b1;
      r_data_buf <= mem_if.data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cancel <= 1'b0;
    end else if (w_flush && w_need_data && !r_data_got && !w_data_ok) begin
      r_cancel <= 1'b1;
    end else if (w_data_ok && r_cancel) begin
      r_cancel <= 1'b0;
    end
  end

  assign w_rdata_sel = r_data_got ? r_data_buf : mem_if.data_sram_rdata;
  assign w_byte      = 8'(w_rdata_sel >> {w_result[1:0], 3'b000});
  assign w_half      = w_result[1] ? w_rdata_sel[31:16] : w_rdata_sel[15:0];

  always_comb begin
    w_load_value = w_rdata_sel;
    unique case (w_memINS_rec)
      2'b01:   w_load_value = {{24{w_load_sign & w_byte[7]}}, w_byte};
      2'b10:   w_load_value = {{16{w_load_sign & w_half[15]}}, w_half};
      default: w_load_value = w_rdata_sel;
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_load_value : w_result;
  assign w_out_regW     = w_regW & ~w_flush;
  assign w_load_pending = r_mem_valid & w_res_from_mem & ~w_ready_go;
  assign w_exist_csrR   = (w_csr_instRec != 2'b00) | (w_rdcnt_REC != 2'b00);

  assign w_wb_bus = {w_memW, w_out_regW, w_regWAddr, w_res_from_mem, w_final_result,
                     r_bus[135:0]};
  assign w_id_bus = {r_mem_valid, w_load_pending, r_mem_valid & w_out_regW,
                     r_mem_valid ? w_regWAddr : 5'd0, w_final_result, w_exist_csrR};

  assign mem_if.mem_allowin                = w_allowin;
  assign mem_if.mem_to_wb_valid            = w_to_wb_valid;
  assign mem_if.mem_to_wb_bus              = w_wb_bus;
  assign mem_if.mem_to_id_bus              = w_id_bus;
  // Combinational so execute can suppress a request issued in this same cycle.
  assign mem_if.mem_to_exe_flush_excp_ertn = (r_mem_valid & (w_excp | w_ertn)) | w_flush;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extraction, stalls, buffered responses,
// flush-orphaned responses, exceptions and decode forwarding.
module tb_mem_stage;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if mif ();

  mem_stage u_dut (
    .clk    (clk),
    .resetn (resetn),
    .mem_if (mif)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [175:0] mk_bus(input logic mw, input logic rw,
                                          input logic [4:0] ad, input logic rfm,
                                          input logic [31:0] res, input logic [1:0] ins,
                                          input logic sgn, input logic [1:0] csr,
                                          input logic ex, input logic er,
                                          input logic [31:0] pc);
    return {mw, rw, ad, rfm, res, ins, sgn, 32'hAAAA_0000, 32'hBBBB_0000, 14'h0, csr,
            ex, er, 14'h0, 2'b00, 3'b000, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [175:0] bus);
    mif.exe_to_mem_valid = 1'b1;
    mif.exe_to_mem_bus   = bus;
    tick();
    mif.exe_to_mem_valid = 1'b0;
    mif.exe_to_mem_bus   = '0;
  endtask

  // Load whose response arrives in its first cycle of residency.
  task automatic run_load(input string tag, input logic [1:0] ins, input logic sgn,
                          input logic [31:0] res, input logic [31:0] rdata,
                          input logic [31:0] exp);
    enter(mk_bus(1'b0, 1'b1, 5'd3, 1'b1, res, ins, sgn, 2'b00, 1'b0, 1'b0, 32'h100));
    mif.data_sram_data_ok = 1'b1;
    mif.data_sram_rdata   = rdata;
    #1;
    check({tag, "_valid"}, 32'(mif.mem_to_wb_valid), 32'd1);
    check(tag, mif.mem_to_wb_bus[167:136], exp);
    tick();
    mif.data_sram_data_ok = 1'b0;
    mif.data_sram_rdata   = 32'd0;
  endtask

  initial begin
    mif.exe_to_mem_valid  = 1'b0;
    mif.exe_to_mem_bus    = '0;
    mif.wb_allowin        = 1'b0;
    mif.wb_to_mem_flush   = 1'b0;
    mif.data_sram_data_ok = 1'b0;
    mif.data_sram_rdata   = 32'd0;
    repeat (2) tick();
    check("rst_allowin", 32'(mif.mem_allowin), 32'd1);
    check("rst_wb_valid", 32'(mif.mem_to_wb_valid), 32'd0);
    check("rst_flush_out", 32'(mif.mem_to_exe_flush_excp_ertn), 32'd0);
    check("rst_id_valid", 32'(mif.mem_to_id_bus[40]), 32'd0);
    resetn = 1'b1;
    tick();

    // ld.w: one-cycle stall, decode sees a pending load on r5.
    mif.wb_allowin       = 1'b1;
    mif.exe_to_mem_valid = 1'b1;
    mif.exe_to_mem_bus   = mk_bus(1'b0, 1'b1, 5'd5, 1'b1, 32'h1000, 2'b11, 1'b0, 2'b00,
                                  1'b0, 1'b0, 32'h1C00_0040);
    #1;
    check("ldw_allowin_empty", 32'(mif.mem_allowin), 32'd1);
    tick();
    mif.exe_to_mem_valid = 1'b0;
    #1;
    check("ldw_wait_valid", 32'(mif.mem_to_wb_valid), 32'd0);
    check("ldw_load_pending", 32'(mif.mem_to_id_bus[39]), 32'd1);
    check("ldw_id_addr", 32'(mif.mem_to_id_bus[37:33]), 32'd5);
    check("ldw_wait_allowin", 32'(mif.mem_allowin), 32'd0);
    tick();
    mif.data_sram_data_ok = 1'b1;
    mif.data_sram_rdata   = 32'h89AB_CDEF;
    #1;
    check("ldw_done_valid", 32'(mif.mem_to_wb_valid), 32'd1);
    check("ldw_result", mif.mem_to_wb_bus[167:136], 32'h89AB_CDEF);
    check("ldw_pending_clr", 32'(mif.mem_to_id_bus[39]), 32'd0);
    check("ldw_fwd_data", mif.mem_to_id_bus[32:1], 32'h89AB_CDEF);
    check("ldw_pc", mif.mem_to_wb_bus[31:0], 32'h1C00_0040);
    check("ldw_regw", 32'(mif.mem_to_wb_bus[174]), 32'd1);
    tick();
    mif.data_sram_data_ok = 1'b0;
    #1;
    check("ldw_left", 32'(mif.mem_to_wb_valid), 32'd0);

    // Extraction vectors.
    run_load("ldb_s_off3", 2'b01, 1'b1, 32'h1003, 32'h80FF_FFFF, 32'hFFFF_FF80);
    run_load("ldbu_off3", 2'b01, 1'b0, 32'h1003, 32'h80FF_FFFF, 32'h0000_0080);
    run_load("ldh_s_off2", 2'b10, 1'b1, 32'h1002, 32'h8001_1234, 32'hFFFF_8001);
    run_load("ldhu_off0", 2'b10, 1'b0, 32'h1000, 32'h8001_9234, 32'h0000_9234);
    run_load("ldb_s_off1", 2'b01, 1'b1, 32'h1001, 32'h0000_7F00, 32'h0000_007F);

    // Response arrives while write-back is stalled; buffered value must hold.
    enter(mk_bus(1'b0, 1'b1, 5'd6, 1'b1, 32'h2000, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 32'h200));
    mif.wb_allowin        = 1'b0;
    mif.data_sram_data_ok = 1'b1;
    mif.data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("hold_ok_valid", 32'(mif.mem_to_wb_valid), 32'd1);
    check("hold_ok_allowin", 32'(mif.mem_allowin), 32'd0);
    tick();
    mif.data_sram_data_ok = 1'b0;
    mif.data_sram_rdata   = 32'h1111_1111;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("hold_valid", 32'(mif.mem_to_wb_valid), 32'd1);
      check("hold_result", mif.mem_to_wb_bus[167:136], 32'hDEAD_BEEF);
      tick();
    end
    mif.wb_allowin = 1'b1;
    #1;
    check("hold_accept_result", mif.mem_to_wb_bus[167:136], 32'hDEAD_BEEF);
    check("hold_accept_allowin", 32'(mif.mem_allowin), 32'd1);
    tick();
    mif.data_sram_rdata = 32'd0;
    #1;
    check("hold_left", 32'(mif.mem_to_wb_valid), 32'd0);

    // Flush while a load waits; its late response must not complete the next load.
    enter(mk_bus(1'b0, 1'b1, 5'd8, 1'b1, 32'h3000, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 32'h300));
    mif.wb_to_mem_flush = 1'b1;
    #1;
    check("fl_flush_out", 32'(mif.mem_to_exe_flush_excp_ertn), 32'd1);
    check("fl_wb_valid", 32'(mif.mem_to_wb_valid), 32'd0);
    check("fl_regw_mask", 32'(mif.mem_to_wb_bus[174]), 32'd0);
    tick();
    mif.wb_to_mem_flush  = 1'b0;
    mif.exe_to_mem_valid = 1'b1;
    mif.exe_to_mem_bus   = mk_bus(1'b0, 1'b1, 5'd9, 1'b1, 32'h3100, 2'b11, 1'b0, 2'b00,
                                  1'b0, 1'b0, 32'h310);
    #1;
    check("fl_allowin_after", 32'(mif.mem_allowin), 32'd1);
    tick();
    mif.exe_to_mem_valid  = 1'b0;
    mif.data_sram_data_ok = 1'b1;
    mif.data_sram_rdata   = 32'hBAD0_BAD0;
    #1;
    check("fl_stale_valid", 32'(mif.mem_to_wb_valid), 32'd0);
    check("fl_stale_pending", 32'(mif.mem_to_id_bus[39]), 32'd1);
    tick();
    mif.data_sram_data_ok = 1'b0;
    mif.data_sram_rdata   = 32'd0;
    #1;
    check("fl_post_stale_valid", 32'(mif.mem_to_wb_valid), 32'd0);
    tick();
    mif.data_sram_data_ok = 1'b1;
    mif.data_sram_rdata   = 32'h0000_C0DE;
    #1;
    check("fl_own_valid", 32'(mif.mem_to_wb_valid), 32'd1);
    check("fl_own_result", mif.mem_to_wb_bus[167:136], 32'h0000_C0DE);
    tick();
    mif.data_sram_data_ok = 1'b0;
    mif.data_sram_rdata   = 32'd0;

    // Excepting store: no wait, flush toward execute immediately.
    mif.exe_to_mem_valid = 1'b1;
    mif.exe_to_mem_bus   = mk_bus(1'b1, 1'b0, 5'd0, 1'b0, 32'h5000, 2'b11, 1'b0, 2'b00,
                                  1'b1, 1'b0, 32'h500);
    #1;
    check("ex_flush_empty", 32'(mif.mem_to_exe_flush_excp_ertn), 32'd0);
    tick();
    mif.exe_to_mem_valid = 1'b0;
    #1;
    check("ex_flush_out", 32'(mif.mem_to_exe_flush_excp_ertn), 32'd1);
    check("ex_wb_valid", 32'(mif.mem_to_wb_valid), 32'd1);
    check("ex_allowin", 32'(mif.mem_allowin), 32'd1);
    tick();
    check("ex_left", 32'(mif.mem_to_wb_valid), 32'd0);
    check("ex_flush_clr", 32'(mif.mem_to_exe_flush_excp_ertn), 32'd0);

    enter(mk_bus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 32'h600));
    check("ertn_flush_out", 32'(mif.mem_to_exe_flush_excp_ertn), 32'd1);
    check("ertn_wb_valid", 32'(mif.mem_to_wb_valid), 32'd1);
    tick();

    // CSR read is flagged to decode; plain ALU result forwarded.
    enter(mk_bus(1'b0, 1'b1, 5'd4, 1'b0, 32'h77, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 32'h700));
    check("csr_exist", 32'(mif.mem_to_id_bus[0]), 32'd1);
    check("csr_fwd", mif.mem_to_id_bus[32:1], 32'h77);
    check("csr_wb_valid", 32'(mif.mem_to_wb_valid), 32'd1);
    tick();

    // Store waits for data_ok; rdata ignored.
    enter(mk_bus(1'b1, 1'b0, 5'd0, 1'b0, 32'h4004, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 32'h800));
    check("st_wait_valid", 32'(mif.mem_to_wb_valid), 32'd0);
    check("st_no_csr", 32'(mif.mem_to_id_bus[0]), 32'd0);
    check("st_not_pending", 32'(mif.mem_to_id_bus[39]), 32'd0);
    tick();
    mif.data_sram_data_ok = 1'b1;
    mif.data_sram_rdata   = 32'hFFFF_FFFF;
    #1;
    check("st_done_valid", 32'(mif.mem_to_wb_valid), 32'd1);
    check("st_result", mif.mem_to_wb_bus[167:136], 32'h0000_4004);
    tick();
    mif.data_sram_data_ok = 1'b0;
    mif.data_sram_rdata   = 32'd0;

    // Reset while a load waits.
    enter(mk_bus(1'b0, 1'b1, 5'd2, 1'b1, 32'h9000, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 32'h900));
    resetn = 1'b0;
    tick();
    check("rstw_wb_valid", 32'(mif.mem_to_wb_valid), 32'd0);
    check("rstw_allowin", 32'(mif.mem_allowin), 32'd1);
    check("rstw_id_valid", 32'(mif.mem_to_id_bus[40]), 32'd0);
    resetn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Latches the execute-stage bus and waits for the data-SRAM response of any load or store issued there. Extracts and extends load data, then hands results to write-back.
- Provides RAW forwarding/blocking information to decode. Drives the exception/ERTN flush that kills execute.
- Tracks responses orphaned by a flush so stale data_ok pulses never complete a newer instruction.

Parameters:
- EXE_TO_MEM_WD, 176, width of exe_to_mem_bus.
- MEM_TO_WB_WD, 176, width of mem_to_wb_bus.
- MEM_TO_ID_WD, 41, width of mem_to_id_bus.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- mem_allowin  out  1  stage can accept from execute
- exe_to_mem_valid  in  1  execute presents a valid instruction
- exe_to_mem_bus  in  176  {memW, regW, regWAddr[4:0], res_from_mem, result[31:0], memINS_rec[1:0], load_sign, DataA[31:0], DataB[31:0], csr_num[13:0], csr_instRec[1:0], excp, ertn, excp_num[13:0], rdcnt_REC[1:0], tlb_ins_rec[2:0], pc[31:0]}, MSB first
- wb_allowin  in  1  write-back can accept
- mem_to_wb_valid  out  1  valid toward write-back
- mem_to_wb_bus  out  176  same layout as input; result field replaced by final result; regW masked
- mem_to_id_bus  out  41  {mem_valid, load_pending, regW, regWAddr (0 when invalid), final_result[31:0], exist_csrR}
- wb_to_mem_flush  in  1  write-back is committing an exception/ERTN
- mem_to_exe_flush_excp_ertn  out  1  kill execute and suppress its SRAM request
- data_sram_data_ok  in  1  response handshake
- data_sram_rdata  in  32  load data

Behaviour:
- Pipeline register:
  - mem_valid resets to 0, and is cleared when wb_to_mem_flush=1.
  - Otherwise, when mem_allowin=1, mem_valid<=exe_to_mem_valid.
  - The bus is latched when mem_allowin & exe_to_mem_valid. Bus contents are don't-care after reset.
- need_data = mem_valid & (memW | res_from_mem) & ~excp. A request was accepted in execute for exactly these instructions.
- Response capture:
  - When data_ok=1, cancel=0, need_data=1 and data_got=0: set data_got and capture rdata into data_buf.
  - data_got and data_buf clear when the instruction leaves (mem_to_wb_valid & wb_allowin), on flush, or on reset.
  - data_ok may arrive in the first cycle of residency or any later cycle.
- cancel flag:
  - Set when wb_to_mem_flush=1, need_data=1, data_got=0 and data_ok=0 in the same cycle.
  - Cleared on the next data_ok, which is discarded and never captured.
  - Reset value 0.
  - While cancel=1, an incoming load keeps waiting. Its own data_ok is the one after the discarded one.
  - At most one outstanding request exists, so one flag suffices.
- mem_ready_go = ~need_data | data_got | (data_ok & ~cancel).
- mem_allowin = ~mem_valid | mem_ready_go & wb_allowin.
- mem_to_wb_valid = mem_valid & mem_ready_go & ~wb_to_mem_flush.
- rdata_sel = data_got ? data_buf : data_sram_rdata.
- Load extraction, with off = result[1:0]:
  - memINS_rec=01: byte at rdata_sel[8*off+7 : 8*off]; sign-extended if load_sign, else zero-extended.
  - memINS_rec=10: half at off[1] (bits 15:0 or 31:16), extended the same way.
  - memINS_rec=11: full word.
- final_result = res_from_mem ? load_value : result.
- Outgoing regW = regW & ~wb_to_mem_flush.
- load_pending = mem_valid & res_from_mem & ~mem_ready_go. While it is 1, decode stalls instead of forwarding.
- exist_csrR = (csr_instRec!=0) | (rdcnt_REC!=0).
- mem_to_exe_flush_excp_ertn = mem_valid & (excp | ertn) | wb_to_mem_flush. The term is combinational so a same-cycle execute request is suppressed.
- Stores: data_ok completes the instruction; rdata is ignored.
- Reset mid-wait: all state returns to 0. Any later response is the responsibility of the SRAM bridge reset.
- All outputs are 0 or don't-care while resetn=0 (mem_valid=0 forces the valid fields low).

Test Plan:
- ld.w at result=0x1000 enters; data_ok+rdata=0x89ABCDEF on the next cycle; wb_allowin=1 -> one-cycle stall, then mem_to_wb_valid=1 with final_result=0x89ABCDEF.
- ld.b with load_sign=1, off=3, rdata=0x80FFFFFF -> 0xFFFFFF80. ld.bu at the same off -> 0x00000080. ld.h with load_sign=1, off=2, rdata=0x8001_1234 -> 0xFFFF8001.
- Load data_ok arrives while wb_allowin=0 for 3 cycles -> data_got=1, data_buf holds the value, the result is unchanged when wb accepts, and no second data_ok is needed.
- wb_to_mem_flush while a load waits; stale data_ok arrives 2 cycles later as a new ld.w enters -> stale data is dropped, cancel goes 1→0, and the new load completes only on its own data_ok with its own data.
- Instruction with excp=1 and memW=1 -> no wait; mem_to_exe_flush_excp_ertn=1 in the same cycle; passes to wb the next cycle if wb_allowin=1.
- Load waiting with regWAddr=5 -> mem_to_id_bus shows load_pending=1 and regWAddr=5; after data_ok, load_pending=0 and forwarded data is correct.
